// File: rtl/sched_pkg.sv
// Shared scheduler types: slot/entry layout and the command opcodes used by the
// ready table and the max-priority sorter.
package sched_pkg;

  localparam int NUM_SLOTS  = 6;
  localparam int PRIO_W     = 4;
  localparam int ID_W       = 4;
  localparam int SLOT_IDX_W = 3;
  localparam int ENTRY_W    = PRIO_W + ID_W;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_ADD      = 2'b01,
    OP_REMOVE   = 2'b10,
    OP_SET_PRIO = 2'b11
  } cmd_op_e;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [ID_W-1:0]   id;
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [PRIO_W-1:0] base_prio;
    logic [PRIO_W-1:0] eff_prio;
  } slot_t;

  function automatic entry_t pack_entry(input logic [PRIO_W-1:0] prio,
                                        input logic [ID_W-1:0]   id);
    entry_t e;
    e.prio = prio;
    e.id   = id;
    return e;
  endfunction

endpackage

// File: rtl/task_ready_table_if.sv
// Command channel from the CPU-side bus bridge into the ready table.
interface task_ready_table_if;
  import sched_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_op_e               cmd_op;
  logic [SLOT_IDX_W-1:0] cmd_slot;
  logic [PRIO_W-1:0]     cmd_prio;
  logic [ID_W-1:0]       cmd_id;
  logic                  cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_slot, cmd_prio, cmd_id,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_slot, cmd_prio, cmd_id,
    output cmd_ready, cmd_err
  );

endinterface

// File: rtl/age_timer.sv
// Free-running period counter; tick is high for the last cycle of each period.
module age_timer #(
  parameter int AGE_PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(AGE_PERIOD - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/task_ready_table.sv
// Ready-task register file: slot commands, periodic priority aging, and reload
// of the running task's priority so its accumulated aging is discarded.
module task_ready_table
  import sched_pkg::*;
#(
  parameter int AGE_PERIOD = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  task_ready_table_if.slave    cmd,
  input  logic                 run_valid,
  input  logic [ID_W-1:0]      run_id,
  output logic [ENTRY_W-1:0]   slot0,
  output logic [ENTRY_W-1:0]   slot1,
  output logic [ENTRY_W-1:0]   slot2,
  output logic [ENTRY_W-1:0]   slot3,
  output logic [ENTRY_W-1:0]   slot4,
  output logic [ENTRY_W-1:0]   slot5,
  output logic [NUM_SLOTS-1:0] occupancy
);

  slot_t slots_q [NUM_SLOTS];
  slot_t slots_d [NUM_SLOTS];

  logic tick;
  logic dup;
  logic tgt_valid;
  logic in_range;
  logic prio_ok;
  logic cmd_ok;
  logic accept;
  logic err_q;

  age_timer #(.AGE_PERIOD(AGE_PERIOD)) u_age_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Stalling on the tick cycle keeps commands and aging from ever colliding.
  assign cmd.cmd_ready = !rst && !tick;
  assign cmd.cmd_err   = err_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    dup       = 1'b0;
    tgt_valid = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots_q[i].valid && slots_q[i].id == cmd.cmd_id) dup = 1'b1;
      if (cmd.cmd_slot == SLOT_IDX_W'(i)) tgt_valid = slots_q[i].valid;
    end
    in_range = cmd.cmd_slot < SLOT_IDX_W'(NUM_SLOTS);
    prio_ok  = cmd.cmd_prio != '0;

    unique case (cmd.cmd_op)
      OP_NOP:      cmd_ok = 1'b1;
      OP_ADD:      cmd_ok = in_range && !tgt_valid && prio_ok && !dup;
      OP_REMOVE:   cmd_ok = in_range && tgt_valid;
      OP_SET_PRIO: cmd_ok = in_range && tgt_valid && prio_ok;
      default:     cmd_ok = 1'b0;
    endcase
  end

  // Per slot: running-task reload or aging, then a command overrides both.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slots_d[i] = slots_q[i];

      if (slots_q[i].valid && run_valid && slots_q[i].id == run_id) begin
        slots_d[i].eff_prio = slots_q[i].base_prio;
      end else if (tick && slots_q[i].valid && slots_q[i].eff_prio != '1) begin
        slots_d[i].eff_prio = slots_q[i].eff_prio + PRIO_W'(1);
      end

      if (accept && cmd_ok && cmd.cmd_slot == SLOT_IDX_W'(i)) begin
        unique case (cmd.cmd_op)
          OP_ADD: begin
            slots_d[i].valid     = 1'b1;
            slots_d[i].id        = cmd.cmd_id;
            slots_d[i].base_prio = cmd.cmd_prio;
            slots_d[i].eff_prio  = cmd.cmd_prio;
          end
          OP_REMOVE: begin
            slots_d[i] = '0;
          end
          OP_SET_PRIO: begin
            slots_d[i].base_prio = cmd.cmd_prio;
            slots_d[i].eff_prio  = cmd.cmd_prio;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= slots_d[i];
      err_q <= accept && !cmd_ok;
    end
  end

  function automatic logic [ENTRY_W-1:0] slot_out(input slot_t s);
    return s.valid ? pack_entry(s.eff_prio, s.id) : '0;
  endfunction

  assign slot0 = slot_out(slots_q[0]);
  assign slot1 = slot_out(slots_q[1]);
  assign slot2 = slot_out(slots_q[2]);
  assign slot3 = slot_out(slots_q[3]);
  assign slot4 = slot_out(slots_q[4]);
  assign slot5 = slot_out(slots_q[5]);

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) occupancy[i] = slots_q[i].valid;
  end

endmodule

// File: tb/tb_task_ready_table.sv
// Directed plus randomized bench for task_ready_table against a cycle-count
// based reference model of the ready table.
module tb_task_ready_table;
  import sched_pkg::*;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_valid;
  logic [3:0] run_id;
  logic [7:0] sl [6];
  logic [5:0] occ;

  task_ready_table_if bus();

  task_ready_table #(.AGE_PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus),
    .run_valid (run_valid),
    .run_id    (run_id),
    .slot0     (sl[0]),
    .slot1     (sl[1]),
    .slot2     (sl[2]),
    .slot3     (sl[3]),
    .slot4     (sl[4]),
    .slot5     (sl[5]),
    .occupancy (occ)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: cyc counts clock edges since the last reset edge.
  bit m_valid [6];
  int m_id    [6];
  int m_base  [6];
  int m_eff   [6];
  int cyc     = 0;
  bit exp_err = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_slot(input int i);
    logic [7:0] v;
    v = 8'h00;
    if (m_valid[i]) v = 8'((m_eff[i] << 4) | m_id[i]);
    return v;
  endfunction

  function automatic bit ready_pred();
    return !rst && ((cyc % P) != P - 1);
  endfunction

  task automatic cycle();
    bit ready_exp, tick, accept, ok;
    int s, p, d;
    logic [7:0] occ_exp;
    #1;
    ready_exp = ready_pred();
    check("cmd_ready", {7'b0, bus.cmd_ready}, {7'b0, ready_exp});

    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_valid[i] = 0; m_id[i] = 0; m_base[i] = 0; m_eff[i] = 0;
      end
      cyc = 0;
      exp_err = 0;
    end else begin
      tick   = (cyc % P) == P - 1;
      accept = bus.cmd_valid && ready_exp;
      s = int'(bus.cmd_slot);
      p = int'(bus.cmd_prio);
      d = int'(bus.cmd_id);
      ok = 1;
      case (bus.cmd_op)
        OP_ADD: begin
          if (s >= 6 || p == 0) ok = 0;
          else if (m_valid[s]) ok = 0;
          for (int j = 0; j < 6; j++) if (m_valid[j] && m_id[j] == d) ok = 0;
        end
        OP_REMOVE:   ok = (s < 6) && m_valid[s < 6 ? s : 0];
        OP_SET_PRIO: ok = (s < 6) && (p != 0) && m_valid[s < 6 ? s : 0];
        default:     ok = 1;
      endcase
      for (int i = 0; i < 6; i++) begin
        if (m_valid[i] && run_valid && m_id[i] == int'(run_id)) m_eff[i] = m_base[i];
        else if (tick && m_valid[i] && m_eff[i] < 15) m_eff[i] = m_eff[i] + 1;
      end
      if (accept && ok) begin
        case (bus.cmd_op)
          OP_ADD: begin
            m_valid[s] = 1; m_id[s] = d; m_base[s] = p; m_eff[s] = p;
          end
          OP_REMOVE: begin
            m_valid[s] = 0; m_id[s] = 0; m_base[s] = 0; m_eff[s] = 0;
          end
          OP_SET_PRIO: begin
            m_base[s] = p; m_eff[s] = p;
          end
          default: ;
        endcase
      end
      exp_err = accept && !ok;
      cyc++;
    end

    @(posedge clk);
    #1;
    occ_exp = 8'h00;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("slot%0d", i), sl[i], m_slot(i));
      occ_exp[i] = m_valid[i];
    end
    check("occupancy", {2'b0, occ}, occ_exp);
    check("cmd_err", {7'b0, bus.cmd_err}, {7'b0, exp_err});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // Holds the command until the model says the table accepts it.
  task automatic applyStimulus(input cmd_op_e op, input int slot, input int prio, input int id);
    bit was_ready;
    int n;
    bus.cmd_op    = op;
    bus.cmd_slot  = 3'(slot);
    bus.cmd_prio  = 4'(prio);
    bus.cmd_id    = 4'(id);
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      was_ready = ready_pred();
      cycle();
      n++;
    end while (!was_ready && n < 4);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    run_valid     = 1'b0;
    run_id        = 4'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_slot  = 3'd0;
    bus.cmd_prio  = 4'd0;
    bus.cmd_id    = 4'd0;

    // Reset then idle
    do_reset(3);
    idle(6);
    check("idle_occ", {2'b0, occ}, 8'h00);

    // Basic add and remove
    applyStimulus(OP_ADD, 2, 5, 3);
    check("add_slot2", sl[2], 8'h53);
    check("add_occ", {2'b0, occ}, 8'h04);
    applyStimulus(OP_REMOVE, 2, 0, 0);
    check("remove_slot2", sl[2], 8'h00);

    // Error cases
    applyStimulus(OP_ADD, 2, 5, 3);
    applyStimulus(OP_ADD, 2, 7, 9);
    check("err_occupied", {7'b0, bus.cmd_err}, 8'h01);
    check("occupied_keep", sl[2], 8'h53);
    idle(1);
    applyStimulus(OP_ADD, 4, 6, 3);
    check("err_dup_id", {7'b0, bus.cmd_err}, 8'h01);
    check("dup_slot4", sl[4], 8'h00);
    applyStimulus(OP_ADD, 5, 0, 7);
    check("err_prio0", {7'b0, bus.cmd_err}, 8'h01);
    applyStimulus(OP_REMOVE, 1, 0, 0);
    check("err_remove_empty", {7'b0, bus.cmd_err}, 8'h01);
    applyStimulus(OP_ADD, 6, 4, 8);
    check("err_slot6", {7'b0, bus.cmd_err}, 8'h01);
    applyStimulus(OP_SET_PRIO, 2, 9, 0);
    check("set_prio", sl[2], 8'h93);
    idle(2);

    // Aging to saturation
    do_reset(2);
    applyStimulus(OP_ADD, 0, 1, 1);
    idle(70);
    check("age_saturate", sl[0], 8'hF1);

    // Running-task exclusion
    do_reset(2);
    run_valid = 1'b1;
    run_id    = 4'd2;
    applyStimulus(OP_ADD, 0, 2, 1);
    applyStimulus(OP_ADD, 1, 2, 2);
    idle(12);
    check("run_excluded", sl[1], 8'h22);
    run_id = 4'd1;
    cycle();
    check("run_reload", sl[0], 8'h21);
    run_valid = 1'b0;

    // Reset mid-operation
    idle(8);
    bus.cmd_op    = OP_ADD;
    bus.cmd_slot  = 3'd3;
    bus.cmd_prio  = 4'd4;
    bus.cmd_id    = 4'd5;
    bus.cmd_valid = 1'b1;
    rst = 1'b1;
    cycle();
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    check("midrst_slot0", sl[0], 8'h00);
    check("midrst_occ", {2'b0, occ}, 8'h00);
    idle(P + 2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst           = ($urandom_range(0, 60) == 0);
      bus.cmd_valid = ($urandom_range(0, 9) < 7);
      bus.cmd_op    = cmd_op_e'($urandom_range(0, 3));
      bus.cmd_slot  = 3'($urandom_range(0, 7));
      bus.cmd_prio  = 4'($urandom_range(0, 15));
      bus.cmd_id    = 4'($urandom_range(0, 7));
      run_valid     = ($urandom_range(0, 1) == 1);
      run_id        = 4'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
